uart_rx_cfg: RTL and testbench

//  Configurable UART receiver: second-generation replacement for the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg_pkg.sv | 25 ++
 rtl/uart_rx_cfg_if.sv | 29 ++
 rtl/uart_rx_cfg_sync.sv | 32 +++
 rtl/uart_rx_cfg.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg_pkg
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity-mode codes and a helper that decides whether a parity bit is present.
// -----------------------------------------------------------------------------
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg_if
// Host-side bundle of the UART receiver: received word, status flags and the
// valid/read handshake.
//   master : receiver side (drives data/status, samples rd_en)
//   slave  : host/FIFO side (samples data/status, drives rd_en)
// -----------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            rd_en;
  logic [DBIT-1:0] dout;
  logic            rx_valid;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;
  logic            overrun;

  modport master (
    input  rd_en,
    output dout, rx_valid, rx_done_tick, parity_err, frame_err, break_det, overrun
  );

  modport slave (
    output rd_en,
    input  dout, rx_valid, rx_done_tick, parity_err, frame_err, break_det, overrun
  );
endinterface

// File: rtl/uart_rx_cfg_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg_sync
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
// RST_VAL sets the value both flops take in reset (idle level of the line).
// -----------------------------------------------------------------------------
module uart_rx_cfg_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // stage p0 -> p1: metastability settling
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver. DBIT data bits (LSB first), OVS s_tick pulses per
// bit, runtime parity (none/even/odd) and one or two stop bits. Rejects false
// starts, reports parity/framing/break/overrun and offers a valid/read handshake.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   rx              asynchronous serial line (idle high)
//   s_tick          oversampling strobe, OVS per bit period
//   parity_mode     00 none, 01 even, 10 odd, 11 none (latched at frame start)
//   stop2           1 = check two stop bits (latched at frame start)
//   host            uart_rx_cfg_if.master: dout, rx_valid, rx_done_tick,
//                   parity_err, frame_err, break_det, overrun, rd_en
// -----------------------------------------------------------------------------
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  input  logic         s_tick,
  input  logic [1:0]   parity_mode,
  input  logic         stop2,
  uart_rx_cfg_if.master host
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_sync;

  uart_rx_cfg_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  // FSMD state
  state_t          state_q,  state_n;
  logic [SW-1:0]   s_q,      s_n;
  logic [NW-1:0]   n_q,      n_n;
  logic [DBIT-1:0] b_q,      b_n;
  logic            par_q,    par_n;     // running XOR of data bits
  logic            low_q,    low_n;     // every sample so far was low
  logic            brk_q,    brk_n;
  logic            ferr_q,   ferr_n;
  logic            perr_q,   perr_n;
  logic            sidx_q,   sidx_n;    // 0 = first stop bit, 1 = second
  logic            wait_q,   wait_n;    // after a break, need rx high before a new start
  logic [1:0]      pmode_q,  pmode_n;
  logic            stop2_q,  stop2_n;

  logic            complete;
  logic            brk_fin;
  logic            ferr_fin;

  // output registers
  logic [DBIT-1:0] dout_q;
  logic            valid_q;
  logic            done_q;
  logic            perr_out_q;
  logic            ferr_out_q;
  logic            brk_out_q;
  logic            ovr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      low_q   <= 1'b0;
      brk_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      sidx_q  <= 1'b0;
      wait_q  <= 1'b0;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      n_q     <= n_n;
      b_q     <= b_n;
      par_q   <= par_n;
      low_q   <= low_n;
      brk_q   <= brk_n;
      ferr_q  <= ferr_n;
      perr_q  <= perr_n;
      sidx_q  <= sidx_n;
      wait_q  <= wait_n;
      pmode_q <= pmode_n;
      stop2_q <= stop2_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    s_n      = s_q;
    n_n      = n_q;
    b_n      = b_q;
    par_n    = par_q;
    low_n    = low_q;
    brk_n    = brk_q;
    ferr_n   = ferr_q;
    perr_n   = perr_q;
    sidx_n   = sidx_q;
    wait_n   = wait_q;
    pmode_n  = pmode_q;
    stop2_n  = stop2_q;
    complete = 1'b0;
    brk_fin  = brk_q;
    ferr_fin = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wait_q) begin
          if (rx_sync) wait_n = 1'b0;
        end else if (!rx_sync) begin
          state_n = ST_START;
          s_n     = '0;
          pmode_n = parity_mode;
          stop2_n = stop2;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_sync) begin
              // Genuine start bit: clear per-frame accumulators.
              state_n = ST_DATA;
              s_n     = '0;
              n_n     = '0;
              par_n   = 1'b0;
              low_n   = 1'b1;
              brk_n   = 1'b0;
              ferr_n  = 1'b0;
              perr_n  = 1'b0;
              sidx_n  = 1'b0;
            end else begin
              state_n = ST_IDLE;   // glitch shorter than half a bit
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_n   = '0;
            b_n   = {rx_sync, b_q[DBIT-1:1]};
            par_n = par_q ^ rx_sync;
            low_n = low_q & ~rx_sync;
            if (n_q == N_LAST) begin
              state_n = parity_on(pmode_q) ? ST_PARITY : ST_STOP;
            end else begin
              n_n = n_q + 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_n     = '0;
            perr_n  = (par_q ^ rx_sync) != (pmode_q == PAR_ODD);
            low_n   = low_q & ~rx_sync;
            state_n = ST_STOP;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_n      = '0;
            ferr_fin = ferr_q | ~rx_sync;
            ferr_n   = ferr_fin;
            // Break is judged on the first stop bit only.
            if (!sidx_q) brk_fin = low_q & ~rx_sync;
            brk_n    = brk_fin;
            if (sidx_q || !stop2_q) begin
              // Leave at the stop midpoint so a back-to-back start edge is seen.
              complete = 1'b1;
              state_n  = ST_IDLE;
              wait_n   = brk_fin;
            end else begin
              sidx_n = 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // completion -> host-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= complete;
      if (complete) begin
        dout_q     <= b_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_fin;
        brk_out_q  <= brk_fin;
        valid_q    <= 1'b1;
        // A same-cycle read consumes the old word, so only an unread word overruns.
        if (valid_q && !host.rd_en) ovr_q <= 1'b1;
      end else if (host.rd_en && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign host.dout         = dout_q;
  assign host.rx_valid     = valid_q;
  assign host.rx_done_tick = done_q;
  assign host.parity_err   = perr_out_q;
  assign host.frame_err    = ferr_out_q;
  assign host.break_det    = brk_out_q;
  assign host.overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed and randomized frames for uart_rx_cfg (DBIT=8, OVS=16, s_tick every
// 4 clk). Expected flags come from a frame-level model of the line protocol.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int BT = 64;  // clk per bit period (16 ticks x 4 clk)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic [1:0] tcnt = 2'd0;

  uart_rx_cfg_if #(.DBIT(8)) hif ();

  uart_rx_cfg #(.DBIT(8), .OVS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .host        (hif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (hif.rx_done_tick === 1'b1) done_cnt++;

  // frame-level reference model
  logic [7:0] m_dout = 8'h00;
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_brk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] data, input logic pbit, input logic [1:0] mode,
                             input logic st2, input logic s1, input logic s2);
    bit en;
    int ones;
    en     = (mode == 2'd1) || (mode == 2'd2);
    ones   = $countones(data) + int'(pbit);
    m_perr = en && (((ones % 2) == 1) != (mode == 2'd2));
    m_ferr = !s1 || (st2 && !s2);
    m_brk  = (data == 8'h00) && (!en || !pbit) && !s1;
    m_dout = data;
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_dout"},  32'(hif.dout),       32'(m_dout));
    chk({tag, "_valid"}, 32'(hif.rx_valid),   32'(m_valid));
    chk({tag, "_perr"},  32'(hif.parity_err), 32'(m_perr));
    chk({tag, "_ferr"},  32'(hif.frame_err),  32'(m_ferr));
    chk({tag, "_brk"},   32'(hif.break_det),  32'(m_brk));
    chk({tag, "_ovr"},   32'(hif.overrun),    32'(m_ovr));
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BT) @(negedge clk);
  endtask

  // A low stop bit is shortened so the line is high again well before the next start.
  task automatic drive_stop(input logic b);
    if (b) drive_bit(1'b1);
    else begin
      rx = 1'b0; repeat (40) @(negedge clk);
      rx = 1'b1; repeat (BT - 40) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] mode, input logic st2,
                            input logic pflip, input logic s1, input logic s2, input string tag);
    int   d0;
    logic pbit;
    d0          = done_cnt;
    parity_mode = mode;
    stop2       = st2;
    pbit        = (^data) ^ (mode == 2'd2) ^ pflip;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if ((mode == 2'd1) || (mode == 2'd2)) drive_bit(pbit);
    drive_stop(s1);
    if (st2) drive_stop(s2);
    rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
    model_frame(data, pbit, mode, st2, s1, s2);
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check_flags(tag);
  endtask

  task automatic rd_pulse();
    @(negedge clk) hif.rd_en = 1'b1;
    @(negedge clk) hif.rd_en = 1'b0;
    if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
  endtask

  initial begin
    int d0;
    hif.rd_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_done", 32'(hif.rx_done_tick), 32'd0);
    check_flags("rst");
    reset = 1'b0;
    repeat (2 * BT) @(negedge clk);

    // 8N1 basic frame
    send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t1");
    rd_pulse();
    chk("t1_rd_valid", 32'(hif.rx_valid), 32'd0);

    // even parity, correct and wrong parity bit
    send_frame(8'hA3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "t2_ok");
    rd_pulse();
    send_frame(8'hA3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, "t2_bad");
    rd_pulse();
    send_frame(8'h6B, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "t2_odd");
    rd_pulse();

    // false start: 4 ticks low
    d0 = done_cnt;
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b1; repeat (3 * BT) @(negedge clk);
    chk("t3_nodone", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t3");
    rd_pulse();

    // two stop bits, second one low
    send_frame(8'hF0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, "t4");
    rd_pulse();

    // break: line low for 12 bit times
    d0 = done_cnt;
    parity_mode = 2'd0; stop2 = 1'b0;
    rx = 1'b0; repeat (12 * BT) @(negedge clk);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    model_frame(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_flags("t5");
    rx = 1'b1; repeat (12 * BT) @(negedge clk);
    chk("t5_norestart", 32'(done_cnt - d0), 32'd1);
    rd_pulse();

    // overrun
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t6a");
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t6b");
    rd_pulse();
    chk("t6_rd_valid", 32'(hif.rx_valid), 32'd0);
    chk("t6_rd_ovr",   32'(hif.overrun),  32'd0);

    // reset in the middle of the data bits
    send_frame(8'h5A, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "t7_pre");
    d0 = done_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    rx = 1'b0; repeat (BT / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("t7_rst_done", 32'(hif.rx_done_tick), 32'd0);
    check_flags("t7_rst");
    reset = 1'b0;
    rx = 1'b1;
    repeat (14 * BT) @(negedge clk);
    chk("t7_nodone", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "t7");

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      logic [7:0] data;
      logic [1:0] mode;
      logic       st2, pflip, s1, s2;
      data  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) data = 8'h00;
      mode  = 2'($urandom_range(0, 3));
      st2   = 1'($urandom_range(0, 1));
      pflip = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 5) != 0);
      s2    = ($urandom_range(0, 5) != 0);
      send_frame(data, mode, st2, pflip, s1, s2, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) begin
        rd_pulse();
        chk($sformatf("rnd%0d_rd_valid", k), 32'(hif.rx_valid), 32'(m_valid));
        chk($sformatf("rnd%0d_rd_ovr", k),   32'(hif.overrun),  32'(m_ovr));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
